// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide sequencer (mdu_ctrl, div_core, mdu_ctrl_if).
package mdu_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned ITERS = 32;

    localparam logic [OP_W-1:0] OP_MULT  = 3'd0;
    localparam logic [OP_W-1:0] OP_MULTU = 3'd1;
    localparam logic [OP_W-1:0] OP_DIV   = 3'd2;
    localparam logic [OP_W-1:0] OP_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] OP_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] OP_MTLO  = 3'd5;

    localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    // One HI/LO write transaction
    typedef struct packed {
        logic            hi_we;
        logic            lo_we;
        logic [XLEN-1:0] hi;
        logic [XLEN-1:0] lo;
    } hilo_wr_t;

    function automatic logic is_signed_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_mul_op(input logic [OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_MULTU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Magnitude of x, treating it as signed only when sgn is set
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? (~x + XLEN'(1)) : x;
    endfunction

    // One shift-add step: {upper, lower} where lower starts as the multiplier
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   mcand);
        logic [XLEN:0] sum;
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : (XLEN+1)'(0));
        return {sum, acc[XLEN-1:1]};
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> MDU request and HI/LO write bundle; master is the EX stage, slave is mdu_ctrl.
interface mdu_ctrl_if;

    logic                           req_valid;
    logic [mdu_pkg::OP_W-1:0]       req_op;
    logic [mdu_pkg::XLEN-1:0]       req_a;
    logic [mdu_pkg::XLEN-1:0]       req_b;
    logic                           req_ready;
    logic                           flush;
    logic                           stall;
    logic                           hi_we;
    logic                           lo_we;
    logic [mdu_pkg::XLEN-1:0]       hi_wdata;
    logic [mdu_pkg::XLEN-1:0]       lo_wdata;

    modport master (
        output req_valid, req_op, req_a, req_b, flush,
        input  req_ready, stall, hi_we, lo_we, hi_wdata, lo_wdata
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, flush,
        output req_ready, stall, hi_we, lo_we, hi_wdata, lo_wdata
    );

endinterface

// File: rtl/div_core.sv
// Restoring shift-subtract divider on unsigned magnitudes; 32 iterations after start.
// done_c and the quotient/remainder outputs are combinational and valid in the final iteration cycle.
module div_core
    import mdu_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done_c,
    output logic [XLEN-1:0] quotient_c,
    output logic [XLEN-1:0] remainder_c
);

    logic            busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;

    logic [XLEN:0]   shifted_c;
    logic            ge_c;

    // Partial remainder stays below the divisor, so a 32-bit subtract suffices when ge_c
    assign shifted_c   = {rem_q, quo_q[XLEN-1]};
    assign ge_c        = (shifted_c >= {1'b0, dvs_q});
    assign remainder_c = ge_c ? (shifted_c[XLEN-1:0] - dvs_q) : shifted_c[XLEN-1:0];
    assign quotient_c  = {quo_q[XLEN-2:0], ge_c};
    assign done_c      = busy_q & (cnt_q == CNT_W'(ITERS - 1));

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            busy_d = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = dividend;
            dvs_d  = divisor;
        end else if (busy_q) begin
            rem_d = remainder_c;
            quo_d = quotient_c;
            if (done_c) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO multiply/divide sequencer: accepts one op in IDLE, iterates, then issues one HI/LO write.
// Build option MDU_FAST_MUL_EN: MULT/MULTU complete in one cycle via a combinational multiplier.
module mdu_ctrl
    import mdu_pkg::*;
(
    input  logic      clk,
    input  logic      resetn,
    mdu_ctrl_if.slave bus
);

    mdu_state_e        state_q, state_d;
    hilo_wr_t          wr_q, wr_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic              q_neg_q, q_neg_d;
    logic              r_neg_q, r_neg_d;
    logic              dz_q, dz_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              accept_c;
    logic              sgn_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c;
    logic              div_start_c, div_done_c;
    logic [XLEN-1:0]   div_quo_c, div_rem_c;
    logic [2*XLEN-1:0] mul_res_c;

    assign bus.req_ready = (state_q == ST_IDLE);
    assign accept_c      = bus.req_valid & bus.req_ready & ~bus.flush;
    assign sgn_c         = is_signed_op(bus.req_op);
    assign a_mag_c       = mag(bus.req_a, sgn_c);
    assign b_mag_c       = mag(bus.req_b, sgn_c);

`ifdef MDU_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_prod_c;
    assign fast_prod_c = $signed({sgn_c & bus.req_a[XLEN-1], bus.req_a})
                       * $signed({sgn_c & bus.req_b[XLEN-1], bus.req_b});
    assign bus.stall   = (bus.req_valid & bus.req_ready & is_div_op(bus.req_op))
                       | (state_q == ST_DIV);
`else
    assign bus.stall   = (bus.req_valid & bus.req_ready
                          & (is_mul_op(bus.req_op) | is_div_op(bus.req_op)))
                       | (state_q == ST_MUL) | (state_q == ST_DIV);
`endif

    // A flush arriving in the write cycle cancels the write
    assign bus.hi_we    = wr_q.hi_we & ~bus.flush;
    assign bus.lo_we    = wr_q.lo_we & ~bus.flush;
    assign bus.hi_wdata = wr_q.hi;
    assign bus.lo_wdata = wr_q.lo;

    div_core u_div_core (
        .clk         (clk),
        .resetn      (resetn),
        .start       (div_start_c),
        .abort       (bus.flush),
        .dividend    (a_mag_c),
        .divisor     (b_mag_c),
        .done_c      (div_done_c),
        .quotient_c  (div_quo_c),
        .remainder_c (div_rem_c)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if ((bus.req_op == OP_MTHI) || (bus.req_op == OP_MTLO)) begin
                        state_d = ST_DONE;
                    end else if (is_mul_op(bus.req_op)) begin
`ifdef MDU_FAST_MUL_EN
                        state_d = ST_DONE;
`else
                        state_d = ST_MUL;
`endif
                    end else if (is_div_op(bus.req_op)) begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL:  if (cnt_q == CNT_W'(ITERS - 1)) state_d = ST_DONE;
            ST_DIV:  if (div_done_c) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (bus.flush) state_d = ST_IDLE;
    end

    // Datapath next values and the registered write
    always_comb begin
        wr_d        = wr_q;
        wr_d.hi_we  = 1'b0;
        wr_d.lo_we  = 1'b0;
        a_d         = a_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        div_start_c = 1'b0;
        mul_res_c   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    a_d     = bus.req_a;
                    q_neg_d = sgn_c & (bus.req_a[XLEN-1] ^ bus.req_b[XLEN-1]);
                    r_neg_d = sgn_c & bus.req_a[XLEN-1];
                    dz_d    = (bus.req_b == '0);
                    mcand_d = a_mag_c;
                    acc_d   = {XLEN'(0), b_mag_c};
                    cnt_d   = '0;
                    if (bus.req_op == OP_MTHI) begin
                        wr_d.hi_we = 1'b1;
                        wr_d.hi    = bus.req_a;
                    end else if (bus.req_op == OP_MTLO) begin
                        wr_d.lo_we = 1'b1;
                        wr_d.lo    = bus.req_a;
                    end else if (is_div_op(bus.req_op)) begin
                        div_start_c = 1'b1;
                    end
`ifdef MDU_FAST_MUL_EN
                    if (is_mul_op(bus.req_op)) begin
                        wr_d.hi_we           = 1'b1;
                        wr_d.lo_we           = 1'b1;
                        {wr_d.hi, wr_d.lo}   = fast_prod_c[2*XLEN-1:0];
                    end
`endif
                end
            end
            ST_MUL: begin
                acc_d = mul_step(acc_q, mcand_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(ITERS - 1)) begin
                    mul_res_c          = q_neg_q ? (~acc_d + (2*XLEN)'(1)) : acc_d;
                    wr_d.hi_we         = 1'b1;
                    wr_d.lo_we         = 1'b1;
                    {wr_d.hi, wr_d.lo} = mul_res_c;
                    cnt_d              = '0;
                end
            end
            ST_DIV: begin
                if (div_done_c) begin
                    wr_d.hi_we = 1'b1;
                    wr_d.lo_we = 1'b1;
                    if (dz_q) begin
                        wr_d.lo = DIV_ZERO_Q;
                        wr_d.hi = a_q;
                    end else begin
                        wr_d.lo = q_neg_q ? (~div_quo_c + XLEN'(1)) : div_quo_c;
                        wr_d.hi = r_neg_q ? (~div_rem_c + XLEN'(1)) : div_rem_c;
                    end
                end
            end
            default: ;
        endcase
        if (bus.flush) begin
            wr_d       = wr_q;
            wr_d.hi_we = 1'b0;
            wr_d.lo_we = 1'b0;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q    <= '0;
            a_q     <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
            mcand_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            wr_q    <= wr_d;
            a_q     <= a_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
